// File: rtl/alu_exec_unit.sv
// RV32I/RV-M execute stage: decodes ALU control fields, produces a registered result.
// Single-cycle ALU path plus an optional iterative multiply/divide unit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready; ALU/illegal/divide-special ops complete on accept edge
// MUL   | one shift-add step per cycle, XLEN steps
// DIV   | one restoring-divide step per cycle, XLEN steps
// FIX   | sign correction, half/quotient/remainder select, result out
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e state_q, state_d;

  logic [2*XLEN:0]  acc_q;
  logic [XLEN-1:0]  opb_q;
  logic [SHW-1:0]   cnt_q;
  logic             neg_q;
  logic [2:0]       f3_q;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             zero_q;
  logic             illegal_q, illegal_d;

  logic unused_op;
  assign unused_op = ^{op[6], op[4:0]};

  // ---------------- decode ----------------
  logic sub7, m_enc, is_m, is_mul, is_div, is_ill;
  logic accept, go_mdu;

  assign sub7   = op[5] & funct7[5];
  assign m_enc  = (alu_op == 2'b10) & op[5] & (funct7 == 7'b0000001);
  assign is_m   = m_enc & MDU_EN;
  assign is_ill = (alu_op == 2'b11) | (m_enc & ~MDU_EN);
  assign is_mul = is_m & ~funct3[2];
  assign is_div = is_m & funct3[2];

  // ---------------- single-cycle ALU ----------------
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sra_res;
  logic            lt_s, lt_u;
  logic [XLEN-1:0] alu_res;

  assign shamt   = b[SHW-1:0];
  assign sra_res = $signed(a) >>> shamt;
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = a + b;
      2'b01: alu_res = a - b;
      2'b10: begin
        case (funct3)
          3'b000:  alu_res = sub7 ? (a - b) : (a + b);
          3'b001:  alu_res = a << shamt;
          3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b100:  alu_res = a ^ b;
          3'b101:  alu_res = funct7[5] ? sra_res : (a >> shamt);
          3'b110:  alu_res = a | b;
          default: alu_res = a & b;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // ---------------- MDU operand preparation ----------------
  logic            a_sgn, b_sgn, a_neg, b_neg, neg_d;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            b_zero, div_ovf, div_spec;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    if (!funct3[2]) begin
      a_sgn = (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
      b_sgn = (funct3[1:0] == 2'b01);
    end else begin
      a_sgn = ~funct3[0];
      b_sgn = ~funct3[0];
    end
  end

  assign a_neg = a_sgn & a[XLEN-1];
  assign b_neg = b_sgn & b[XLEN-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;
  // Remainder follows the dividend's sign; products and quotients follow the xor.
  assign neg_d = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);

  assign b_zero   = (b == '0);
  assign div_ovf  = ~funct3[0] & (a == XMIN) & (b == '1);
  assign div_spec = is_div & (b_zero | div_ovf);

  always_comb begin
    if (b_zero) spec_res = funct3[1] ? a : '1;
    else        spec_res = funct3[1] ? '0 : a;
  end

  assign accept = in_valid & in_ready & ~flush;
  assign go_mdu = accept & is_m & ~div_spec;

  // ---------------- iterative step logic ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN:0]   mul_next;
  logic [XLEN:0]     rem_sh, trial;
  logic              q_bit;
  logic [2*XLEN:0]   div_next;

  assign mul_sum  = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};

  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign trial    = rem_sh - {1'b0, opb_q};
  assign q_bit    = ~trial[XLEN];
  assign div_next = {1'b0, (q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], q_bit};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  assign prod_s  = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign quo_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    if (f3_q[2])                 fix_res = f3_q[1] ? rem_s : quo_s;
    else if (f3_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                         fix_res = prod_s[2*XLEN-1:XLEN];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go_mdu) state_d = is_mul ? S_MUL : S_DIV;
      S_MUL, S_DIV: begin
        if (flush)                 state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    out_valid_d = 1'b0;
    result_d    = '0;
    illegal_d   = 1'b0;
    if (state_q == S_FIX) begin
      out_valid_d = ~flush;
      result_d    = fix_res;
    end else if (accept & ~go_mdu) begin
      out_valid_d = 1'b1;
      illegal_d   = is_ill;
      if (is_ill)        result_d = '0;
      else if (div_spec) result_d = spec_res;
      else               result_d = alu_res;
    end
  end

  // ---------------- MDU datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      f3_q  <= 3'b000;
    end else if (go_mdu) begin
      // Multiply: multiplier in the low half, multiplicand added into the high half.
      // Divide: dividend in the low half shifts out into the remainder half.
      acc_q <= is_mul ? {{(XLEN+1){1'b0}}, b_abs} : {{(XLEN+1){1'b0}}, a_abs};
      opb_q <= is_mul ? a_abs : b_abs;
      cnt_q <= '0;
      neg_q <= neg_d;
      f3_q  <= funct3;
    end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
      if (flush) begin
        cnt_q <= '0;
      end else begin
        acc_q <= (state_q == S_MUL) ? mul_next : div_next;
        cnt_q <= cnt_q + SHW'(1);
      end
    end
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        result_q  <= result_d;
        zero_q    <= (result_d == '0);
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: 32-bit instance with MDU, 16-bit instance without.
module tb_alu_exec_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, flush, in_ready, out_valid, zero, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7, op;
  logic [31:0] a, b, result;

  logic        iv16, fl16, ir16, ov16, z16, ill16;
  logic [1:0]  aop16;
  logic [2:0]  f3_16;
  logic [6:0]  f7_16, op16;
  logic [15:0] a16, b16, res16;

  int n_run  = 0;
  int n_fail = 0;

  alu_exec_unit #(.XLEN(32), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(16), .MDU_EN(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .flush(fl16),
    .alu_op(aop16), .funct3(f3_16), .funct7(f7_16), .op(op16), .a(a16), .b(b16),
    .out_valid(ov16), .result(res16), .zero(z16), .illegal(ill16)
  );

  localparam logic [1:0]  T_AOP [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
  localparam logic [2:0]  T_F3  [5] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b000};
  localparam logic [6:0]  T_F7  [5] = '{F7_ALT, F7_ALT, 7'd0, 7'd0, 7'd0};
  localparam logic [6:0]  T_OP  [5] = '{OP_R, OP_I, OP_R, OP_R, OP_R};
  localparam logic [31:0] T_B   [5] = '{32'h10, 32'h4, 32'h10, 32'h10, 32'h10};
  localparam logic [31:0] T_EXP [5] = '{32'hFFFFFFE0, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0};
  localparam logic        T_ILL [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [6:0] o, input logic [31:0] ai, input logic [31:0] bi);
    @(negedge clk);
    alu_op = aop; funct3 = f3; funct7 = f7; op = o; a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drive16(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [6:0] o, input logic [15:0] ai, input logic [15:0] bi);
    @(negedge clk);
    aop16 = aop; f3_16 = f3; f7_16 = f7; op16 = o; a16 = ai; b16 = bi; iv16 = 1'b1;
    @(posedge clk);
    #1 iv16 = 1'b0;
  endtask

  // lat = number of negedges after the accept edge until out_valid; 0 on timeout
  task automatic wait_out(input bit sel16, input int maxc, output int lat);
    lat = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (sel16 ? ov16 : out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_run++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", result); end
    n_run++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b exp 1", zero); end
    n_run++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b exp 0", illegal); end
    n_run++; if ({ir16, ov16, res16, z16, ill16} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_dut16: got %b/%b/%h/%b/%b", ir16, ov16, res16, z16, ill16);
    end
  endtask

  task automatic test_alu();
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive(T_AOP[i], T_F3[i], T_F7[i], T_OP[i], 32'hFFFFFFF0, T_B[i]);
      wait_out(1'b0, 5, lat);
      n_run++; if (lat !== 1) begin n_fail++; $display("FAIL alu%0d_latency: got %0d exp 1", i, lat); end
      n_run++; if (result !== T_EXP[i]) begin n_fail++; $display("FAIL alu%0d_result: got %h exp %h", i, result, T_EXP[i]); end
      n_run++; if (illegal !== T_ILL[i]) begin n_fail++; $display("FAIL alu%0d_illegal: got %b exp %b", i, illegal, T_ILL[i]); end
      n_run++; if (zero !== (T_EXP[i] == 32'h0)) begin n_fail++; $display("FAIL alu%0d_zero: got %b exp %b", i, zero, T_EXP[i] == 32'h0); end
    end
  endtask

  task automatic test_mul();
    logic [31:0] exp_r [4];
    int lat;
    exp_r = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 3'(i), F7_M, OP_R, 32'hFFFFFFFF, 32'h00000002);
      wait_out(1'b0, 60, lat);
      n_run++; if (lat !== 34) begin n_fail++; $display("FAIL mul%0d_latency: got %0d exp 34", i, lat); end
      n_run++; if (result !== exp_r[i]) begin n_fail++; $display("FAIL mul%0d_result: got %h exp %h", i, result, exp_r[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4];
    logic [31:0] exp_r [4];
    int lat;
    f3    = '{3'b100, 3'b110, 3'b101, 3'b111};
    exp_r = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, f3[i], F7_M, OP_R, 32'hFFFFFFF9, 32'h00000002);
      wait_out(1'b0, 60, lat);
      n_run++; if (lat !== 34) begin n_fail++; $display("FAIL div%0d_latency: got %0d exp 34", i, lat); end
      n_run++; if (result !== exp_r[i]) begin n_fail++; $display("FAIL div%0d_result: got %h exp %h", i, result, exp_r[i]); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [4];
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] exp_r [4];
    int lat;
    f3    = '{3'b100, 3'b110, 3'b100, 3'b110};
    sa    = '{32'h00001234, 32'h00001234, 32'h80000000, 32'h80000000};
    sb    = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_r = '{32'hFFFFFFFF, 32'h00001234, 32'h80000000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, f3[i], F7_M, OP_R, sa[i], sb[i]);
      wait_out(1'b0, 60, lat);
      n_run++; if (lat !== 1) begin n_fail++; $display("FAIL spec%0d_latency: got %0d exp 1", i, lat); end
      n_run++; if (result !== exp_r[i]) begin n_fail++; $display("FAIL spec%0d_result: got %h exp %h", i, result, exp_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b011; funct7 = F7_M; op = OP_R;
    a = 32'hFFFFFFFF; b = 32'h2; in_valid = 1'b1;
    @(posedge clk);
    #1 alu_op = 2'b00; funct7 = 7'd0; a = 32'd5; b = 32'd7;
    wait_out(1'b0, 60, lat);
    n_run++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_mul_latency: got %0d exp 34", lat); end
    n_run++; if (result !== 32'h1) begin n_fail++; $display("FAIL b2b_mul_result: got %h exp 00000001", result); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b exp 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_add_valid: got %b exp 1", out_valid); end
    n_run++; if (result !== 32'd12) begin n_fail++; $display("FAIL b2b_add_result: got %h exp 0000000c", result); end
  endtask

  task automatic test_flush();
    int seen;
    drive(2'b10, 3'b100, F7_M, OP_R, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b exp 1", in_ready); end
    seen = out_valid ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_run++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_valid: got %0d pulses exp 0", seen); end
    n_run++; if (result !== 32'd12) begin n_fail++; $display("FAIL flush_result_hold: got %h exp 0000000c", result); end
  endtask

  task automatic test_reset_mid();
    int seen;
    drive(2'b10, 3'b000, F7_M, OP_R, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b exp 1", in_ready); end
    n_run++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h exp 0", result); end
    n_run++; if (zero !== 1'b1) begin n_fail++; $display("FAIL rstmid_zero: got %b exp 1", zero); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_run++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d pulses exp 0", seen); end
  endtask

  task automatic test_mdu_off();
    int lat;
    drive16(2'b10, 3'b000, F7_M, OP_R, 16'd3, 16'd5);
    wait_out(1'b1, 5, lat);
    n_run++; if (lat !== 1) begin n_fail++; $display("FAIL m16_latency: got %0d exp 1", lat); end
    n_run++; if (ill16 !== 1'b1) begin n_fail++; $display("FAIL m16_illegal: got %b exp 1", ill16); end
    n_run++; if (res16 !== 16'h0) begin n_fail++; $display("FAIL m16_result: got %h exp 0", res16); end
    drive16(2'b00, 3'b000, 7'd0, OP_R, 16'h7FFF, 16'h0001);
    wait_out(1'b1, 5, lat);
    n_run++; if (res16 !== 16'h8000) begin n_fail++; $display("FAIL add16_result: got %h exp 8000", res16); end
    n_run++; if (z16 !== 1'b0) begin n_fail++; $display("FAIL add16_zero: got %b exp 0", z16); end
    n_run++; if (ill16 !== 1'b0) begin n_fail++; $display("FAIL add16_illegal: got %b exp 0", ill16); end
    drive16(2'b01, 3'b000, 7'd0, OP_R, 16'h1234, 16'h1234);
    wait_out(1'b1, 5, lat);
    n_run++; if (res16 !== 16'h0) begin n_fail++; $display("FAIL sub16_result: got %h exp 0", res16); end
    n_run++; if (z16 !== 1'b1) begin n_fail++; $display("FAIL sub16_zero: got %b exp 1", z16); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; flush = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'd0; op = 7'd0;
    a = 32'h0; b = 32'h0;
    iv16 = 1'b0; fl16 = 1'b0; aop16 = 2'b00; f3_16 = 3'b000; f7_16 = 7'd0; op16 = 7'd0;
    a16 = 16'h0; b16 = 16'h0;
    #2 rst_n = 1'b0;
    #20;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_alu();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_mdu_off();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
